cla_seq_adder: RTL and testbench
================================

Name: cla_seq_adder

Overview:
- Multi-cycle wide adder built on one shared 4-bit carry-lookahead slice.
- Adds WIDTH-bit operands by sequencing the slice over WIDTH/4 cycles, least-significant nibble first.
- Carry between nibbles is held in a register.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4; elaboration fails otherwise.
- NSLICE, WIDTH/4, derived localparam giving the number of slice passes. Not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to nibble 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, a+b+cin modulo 2^WIDTH.
- cout  out  1  carry out of the MSB nibble.
- busy  out  1  high in RUN and DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: rst high at an edge forces the following.
  - state=IDLE, idx=0, carry_q=0, sum=0, cout=0, out_valid=0.
  - Any operation in progress is abandoned; no out_valid is produced for it.
  - Takes priority over all other events at that edge.
- Output decode:
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
  - busy = (state != IDLE).
- IDLE:
  - At an edge with in_valid && in_ready:
    - Capture a, b into a_q, b_q.
    - carry_q<=cin, idx<=0, sum<=0.
    - Go to RUN.
  - Otherwise hold.
- RUN: one nibble per cycle.
  - Slice inputs: a_q[4*idx+:4], b_q[4*idx+:4], carry_q.
  - At each edge: sum[4*idx+:4] <= slice sum; carry_q <= slice cout.
  - If idx==NSLICE-1: cout <= slice cout, go to DONE.
  - Else: idx <= idx+1.
- DONE:
  - sum and cout are held stable.
  - At an edge with out_ready: go to IDLE.
  - sum and cout keep their value in IDLE until the next accept.
- Latency:
  - Accept at edge T0; out_valid is high from edge T0+NSLICE.
  - The earliest next accept is two edges after out_ready is sampled (DONE->IDLE, then IDLE accept).
- Input stability: a, b, cin, in_valid are ignored outside IDLE. Changes during RUN/DONE do not affect the result.
- Width rule: the result is exact modulo 2^WIDTH; overflow is reported only via cout. The block has no signed-overflow output.
- idx is $clog2(NSLICE) bits, with a minimum of 1 bit. For WIDTH=4 (NSLICE=1), RUN lasts exactly one cycle.
- Simultaneous events: out_ready held high while entering DONE is accepted at the first DONE edge. in_valid seen in the same cycle is not accepted until the block is back in IDLE.

Decomposition:
- Package cla_pkg:
  - SLICE_W=4 constant.
  - Typedef enum logic [1:0] {IDLE, RUN, DONE} cla_state_t.
- Sub-module cla_slice4: purely combinational 4-bit carry-lookahead slice.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Generate p_i=a_i^b_i and g_i=a_i&b_i; each c_{i+1} is the full lookahead sum-of-products.
  - One instance in cla_seq_adder; no other arithmetic in the controller apart from the idx increment.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> out_valid high exactly 4 cycles after accept, sum=0x0000, cout=1.
- WIDTH=16, a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. in_ready low and busy high from accept until the DONE->IDLE edge.
- Backpressure: 0x8000+0x8000, cin=0, out_ready low for 5 cycles after out_valid -> out_valid, sum=0x0000 and cout=1 held constant throughout. Returns to IDLE on the edge where out_ready=1.
- Input isolation: accept 0x00FF+0x0001, then drive a=0xFFFF, b=0xFFFF, in_valid=1 during RUN -> result 0x0100, cout=0. The second request is accepted only after returning to IDLE.
- Reset mid-op: accept any operands, assert rst at the 2nd RUN edge -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0. No stale out_valid ever appears.
- WIDTH=4 instance, a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1, out_valid 1 cycle after accept. Random sweep against a+b+cin reference for WIDTH=4, 8, 16.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and types for the sequential carry-lookahead adder.
package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice; all carries are flat sum-of-products.
module cla_slice4
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:1]   c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ {c[3], c[2], c[1], cin};
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that walks one shared 4-bit lookahead slice over the operands,
// least-significant nibble first, with valid/ready on both sides.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  cla_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

  cla_slice4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          cout_d  = sl_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: WIDTH=4/8/16 instances, directed cases plus a
// randomized sweep against an arithmetic a+b+cin reference.
module tb_cla_seq_adder;

  logic        clk;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic        cout      [3];
  logic [15:0] sumw      [3];
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [15:0] s16;

  int ntests = 0;
  int nfail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(s4), .cout(cout[0]), .busy(busy[0]));

  cla_seq_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(s8), .cout(cout[1]), .busy(busy[1]));

  cla_seq_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(s16), .cout(cout[2]), .busy(busy[2]));

  assign sumw[0] = {12'h000, s4};
  assign sumw[1] = {8'h00, s8};
  assign sumw[2] = s16;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} = a + b + cin over the instance width
  function automatic logic [16:0] ref_add(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic c);
    longint unsigned width, mask, full;
    width = 64'(4 << w);
    mask  = (64'd1 << width) - 64'd1;
    full  = (64'(x) & mask) + (64'(y) & mask) + 64'(c);
    return {1'(full >> width), 16'(full & mask)};
  endfunction

  task automatic start(input int w, input logic [15:0] x, input logic [15:0] y,
                       input logic c);
    a = x; b = y; cin = c;
    in_valid[w] = 1'b1;
    chk("accept_in_ready", 32'(in_ready[w]), 32'd1);
    tick();
    in_valid[w] = 1'b0;
    chk("run_in_ready", 32'(in_ready[w]), 32'd0);
    chk("run_busy", 32'(busy[w]), 32'd1);
  endtask

  task automatic wait_done(input int w, input logic [15:0] x, input logic [15:0] y,
                           input logic c, input int hold);
    logic [16:0] exp;
    int n;
    exp = ref_add(w, x, y, c);
    n = 0;
    while (!out_valid[w] && n < 40) begin
      chk("run_busy_loop", 32'(busy[w]), 32'd1);
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(1 << w));
    chk("sum", 32'(sumw[w]), 32'(exp[15:0]));
    chk("cout", 32'(cout[w]), 32'(exp[16]));
    chk("done_in_ready", 32'(in_ready[w]), 32'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 32'(out_valid[w]), 32'd1);
      chk("hold_sum", 32'(sumw[w]), 32'(exp[15:0]));
      chk("hold_cout", 32'(cout[w]), 32'(exp[16]));
      chk("hold_in_ready", 32'(in_ready[w]), 32'd0);
    end
  endtask

  task automatic release_out(input int w, input logic [15:0] exp_sum, input logic exp_c);
    out_ready[w] = 1'b1;
    tick();
    out_ready[w] = 1'b0;
    chk("idle_out_valid", 32'(out_valid[w]), 32'd0);
    chk("idle_in_ready", 32'(in_ready[w]), 32'd1);
    chk("idle_busy", 32'(busy[w]), 32'd0);
    chk("idle_sum_kept", 32'(sumw[w]), 32'(exp_sum));
    chk("idle_cout_kept", 32'(cout[w]), 32'(exp_c));
  endtask

  task automatic full_op(input int w, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input int hold, input bit early);
    logic [16:0] exp;
    exp = ref_add(w, x, y, c);
    start(w, x, y, c);
    if (early) out_ready[w] = 1'b1;
    wait_done(w, x, y, c, early ? 0 : hold);
    release_out(w, exp[15:0], exp[16]);
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic        rc;
    rst = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_sum", 32'(sumw[i]), 32'd0);
      chk("rst_cout", 32'(cout[i]), 32'd0);
    end

    // Carry ripples through every nibble, consumer always ready
    full_op(2, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b1);
    full_op(2, 16'h1234, 16'h4321, 1'b1, 2, 1'b0);
    // Backpressure on the result side
    full_op(2, 16'h8000, 16'h8000, 1'b0, 5, 1'b0);

    // Input isolation: a second request held during RUN/DONE waits for IDLE
    start(2, 16'h00FF, 16'h0001, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    in_valid[2] = 1'b1;
    wait_done(2, 16'h00FF, 16'h0001, 1'b0, 2);
    chk("iso_sum", 32'(sumw[2]), 32'h0100);
    release_out(2, 16'h0100, 1'b0);
    tick();
    in_valid[2] = 1'b0;
    chk("iso_second_accept", 32'(in_ready[2]), 32'd0);
    wait_done(2, 16'hFFFF, 16'hFFFF, 1'b1, 0);
    release_out(2, 16'hFFFF, 1'b1);

    // Reset at the second RUN edge abandons the operation
    start(2, 16'hABCD, 16'h1357, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready[2]), 32'd1);
    chk("midrst_out_valid", 32'(out_valid[2]), 32'd0);
    chk("midrst_sum", 32'(sumw[2]), 32'd0);
    chk("midrst_cout", 32'(cout[2]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midrst_no_stale", 32'(out_valid[2]), 32'd0);
    end

    // Single-slice instance
    full_op(0, 16'h000F, 16'h000F, 1'b1, 1, 1'b0);
    full_op(1, 16'h00FF, 16'h0001, 1'b0, 0, 1'b1);

    // Random sweep across all widths
    for (int w = 0; w < 3; w++) begin
      for (int n = 0; n < 25; n++) begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        rc = 1'($urandom);
        full_op(w, rx, ry, rc, int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
